// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 5-stage pipeline.
//
// Owns the PC, issues one-at-a-time requests to instruction memory and drives
// the IF/ID pipeline register. Honours the load-use stall controls and the
// EX-stage branch redirect; a redirect flushes IF/ID and kills any in-flight
// fetch.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   PCWrite, IF_ID_Write  hazard-unit stall controls (either low = stall)
//   branch_taken          redirect request from EX
//   branch_target         redirect address (low two bits ignored)
//   imem_req, imem_addr   fetch request pulse and address (from state/pc)
//   imem_rvalid           one response per request, >= 1 cycle after it
//   imem_rdata            instruction word, valid with imem_rvalid
//   if_id_pc/instr/valid  IF/ID pipeline register
// -----------------------------------------------------------------------------

package if_stage_pkg;

    localparam int unsigned XLEN = 32;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            valid;
    } if_id_t;

endpackage

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCWrite,
    input  logic            IF_ID_Write,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid
);

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    // REQ: request on the bus; WAIT: response outstanding; HOLD: word parked
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            discard_q, discard_d;
    logic [XLEN-1:0] hold_buf_q, hold_buf_d;
    if_id_t          if_id_q, if_id_d;

    logic            advance;
    logic            loaded;
    logic [XLEN-1:0] load_instr;

    // Hazard unit drives both controls together; either low is a stall
    assign advance = PCWrite & IF_ID_Write;

    // Fetch bus is decoded straight from the registered state and pc
    assign imem_req  = (state_q == S_REQ) && !reset;
    assign imem_addr = reset ? RESET_PC : pc_q;

    assign if_id_pc    = if_id_q.pc;
    assign if_id_instr = if_id_q.instr;
    assign if_id_valid = if_id_q.valid;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            discard_q     <= 1'b0;
            hold_buf_q    <= '0;
            if_id_q.pc    <= '0;
            if_id_q.instr <= NOP;
            if_id_q.valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            hold_buf_q <= hold_buf_d;
            if_id_q    <= if_id_d;
        end
    end

    // Next-state, pc and IF/ID update
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        hold_buf_d = hold_buf_q;
        if_id_d    = if_id_q;
        loaded     = 1'b0;
        load_instr = '0;

        if (branch_taken) begin
            // Redirect wins over stalls and responses; IF/ID flushes even if held
            pc_d          = branch_target & ALIGN_MASK;
            if_id_d.pc    = '0;
            if_id_d.instr = NOP;
            if_id_d.valid = 1'b0;
            unique case (state_q)
                S_REQ: begin
                    // The request on the bus this cycle is already stale
                    state_d   = S_WAIT;
                    discard_d = 1'b1;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d   = S_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                S_HOLD: begin
                    state_d = S_REQ;
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // Responses outside WAIT are protocol errors and ignored
                    if (imem_rvalid) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else if (advance) begin
                            loaded     = 1'b1;
                            load_instr = imem_rdata;
                        end else begin
                            hold_buf_d = imem_rdata;
                            state_d    = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (advance) begin
                        loaded     = 1'b1;
                        load_instr = hold_buf_q;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase

            if (loaded) begin
                if_id_d.pc    = pc_q;
                if_id_d.instr = load_instr;
                if_id_d.valid = 1'b1;
                pc_d          = pc_q + PC_STEP;
                state_d       = S_REQ;
            end else if (advance) begin
                // Pipeline moves but nothing fetched: insert a bubble
                if_id_d.pc    = pc_q;
                if_id_d.instr = NOP;
                if_id_d.valid = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage -- scoreboard bench for if_stage.
//
// Two instances share every input: one resets to 0, one to 32'hFFFF_FFFC so
// the pc wrap is exercised from reset. A memory model answers the first
// instance's requests with addr ^ 32'hA5A5_0000 after a chosen latency. Each
// cycle the driver advances a transaction-level model of the fetch stage and
// pushes the expected outputs; the monitor pops and compares after each edge.
// -----------------------------------------------------------------------------

module tb_if_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC1 = 32'h0000_0000;
    localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write, if_id_write, branch_taken;
    logic [31:0] branch_target;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        req1, req2, idv1, idv2;
    logic [31:0] addr1, addr2, idpc1, idpc2, idin1, idin2;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RPC1), .NOP(NOP)) u_dut (
        .clk(clk), .reset(reset), .PCWrite(pc_write), .IF_ID_Write(if_id_write),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(req1), .imem_addr(addr1),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_id_pc(idpc1), .if_id_instr(idin1), .if_id_valid(idv1)
    );

    if_stage #(.RESET_PC(RPC2), .NOP(NOP)) u_dut_wrap (
        .clk(clk), .reset(reset), .PCWrite(pc_write), .IF_ID_Write(if_id_write),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_req(req2), .imem_addr(addr2),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_id_pc(idpc2), .if_id_instr(idin2), .if_id_valid(idv2)
    );

    // Fetch stage seen as: wants to issue, has a fetch in flight (possibly
    // killed), or has a fetched word waiting for the pipeline to move.
    typedef struct {
        logic [31:0] pc;
        bit          issue;
        bit          in_flight;
        bit          killed;
        bit          parked;
        logic [31:0] parked_word;
        logic [31:0] id_pc;
        logic [31:0] id_instr;
        bit          id_valid;
    } model_t;

    typedef struct {
        bit          req;
        bit          chk_addr;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
        bit          valid;
    } exp_t;

    typedef struct {
        exp_t d1;
        exp_t d2;
        int   cyc;
    } ent_t;

    ent_t   exp_q[$];
    model_t m1, m2;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int unsigned lat      = 1;
    bit          mem_pending = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_due  = 0;
    bit          force_en = 1'b0;
    logic [31:0] force_val = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp, input int c);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
        end
    endtask

    function automatic model_t model_step(input model_t mi, input logic [31:0] rpc,
                                          input bit rst, input bit pw, input bit iw,
                                          input bit br, input logic [31:0] tgt,
                                          input bit rv, input logic [31:0] rd);
        model_t m;
        bit     adv;
        bit     got;
        logic [31:0] word;
        m    = mi;
        adv  = pw && iw;
        got  = 1'b0;
        word = '0;
        if (rst) begin
            m.pc = rpc; m.issue = 1'b1; m.in_flight = 1'b0; m.killed = 1'b0;
            m.parked = 1'b0; m.parked_word = '0;
            m.id_pc = '0; m.id_instr = NOP; m.id_valid = 1'b0;
            return m;
        end
        if (br) begin
            if (m.issue) begin
                m.issue = 1'b0; m.in_flight = 1'b1; m.killed = 1'b1;
            end else if (m.in_flight) begin
                if (rv) begin
                    m.in_flight = 1'b0; m.killed = 1'b0; m.issue = 1'b1;
                end else begin
                    m.killed = 1'b1;
                end
            end else if (m.parked) begin
                m.parked = 1'b0; m.issue = 1'b1;
            end
            m.pc = {tgt[31:2], 2'b00};
            m.id_pc = '0; m.id_instr = NOP; m.id_valid = 1'b0;
            return m;
        end
        if (m.issue) begin
            m.issue = 1'b0; m.in_flight = 1'b1;
        end else if (m.in_flight && rv) begin
            m.in_flight = 1'b0;
            if (m.killed) begin
                m.killed = 1'b0; m.issue = 1'b1;
            end else if (adv) begin
                got = 1'b1; word = rd;
            end else begin
                m.parked = 1'b1; m.parked_word = rd;
            end
        end else if (m.parked && adv) begin
            m.parked = 1'b0; got = 1'b1; word = m.parked_word;
        end
        if (got) begin
            m.id_pc = m.pc; m.id_instr = word; m.id_valid = 1'b1;
            m.pc = m.pc + 32'd4;
            m.issue = 1'b1;
        end else if (adv) begin
            m.id_pc = m.pc; m.id_instr = NOP; m.id_valid = 1'b0;
        end
        return m;
    endfunction

    function automatic exp_t expect_of(input model_t m, input bit rst,
                                       input logic [31:0] rpc);
        exp_t e;
        e.req      = m.issue && !rst;
        e.chk_addr = e.req || rst;
        e.addr     = rst ? rpc : m.pc;
        e.pc       = m.id_pc;
        e.instr    = m.id_instr;
        e.valid    = m.id_valid;
        return e;
    endfunction

    // One clock cycle of stimulus: drive inputs, play memory, advance models
    task automatic step(input bit rst, input bit pw, input bit iw,
                        input bit br, input logic [31:0] tgt);
        bit          rv;
        logic [31:0] rd;
        ent_t        e;
        @(negedge clk);
        reset         = rst;
        pc_write      = pw;
        if_id_write   = iw;
        branch_taken  = br;
        branch_target = tgt;
        #1;
        rv = 1'b0;
        rd = $urandom;
        if (rst) begin
            mem_pending = 1'b0;
        end else begin
            if (mem_pending && cyc == mem_due) begin
                rv = 1'b1;
                rd = force_en ? force_val : (mem_addr ^ 32'hA5A5_0000);
                force_en    = 1'b0;
                mem_pending = 1'b0;
            end
            if (req1) begin
                chk("one_outstanding", 32'(mem_pending), 32'd0, cyc);
                mem_pending = 1'b1;
                mem_addr    = addr1;
                mem_due     = cyc + int'(lat);
            end
        end
        imem_rvalid = rv;
        imem_rdata  = rd;
        m1 = model_step(m1, RPC1, rst, pw, iw, br, tgt, rv, rd);
        m2 = model_step(m2, RPC2, rst, pw, iw, br, tgt, rv, rd);
        e.d1  = expect_of(m1, rst, RPC1);
        e.d2  = expect_of(m2, rst, RPC2);
        e.cyc = cyc;
        exp_q.push_back(e);
        cyc++;
    endtask

    task automatic compare_dut(input string tag, input exp_t e, input int c,
                               input logic req, input logic [31:0] addr,
                               input logic [31:0] ipc, input logic [31:0] iin,
                               input logic iv);
        chk({tag, ".if_id_pc"},    ipc,        e.pc,          c);
        chk({tag, ".if_id_instr"}, iin,        e.instr,       c);
        chk({tag, ".if_id_valid"}, 32'(iv),    32'(e.valid),  c);
        chk({tag, ".imem_req"},    32'(req),   32'(e.req),    c);
        if (e.chk_addr)
            chk({tag, ".imem_addr"}, addr, e.addr, c);
    endtask

    // Monitor: after each edge, compare against the oldest expectation
    always @(posedge clk) begin
        ent_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compare_dut("dut", e.d1, e.cyc, req1, addr1, idpc1, idin1, idv1);
            compare_dut("dut_wrap", e.d2, e.cyc, req2, addr2, idpc2, idin2, idv2);
        end
    end

    initial begin
        bit          rst, pw, iw, br;
        logic [31:0] tgt;
        reset = 1'b1; pc_write = 1'b1; if_id_write = 1'b1;
        branch_taken = 1'b0; branch_target = '0;
        imem_rvalid = 1'b0; imem_rdata = '0;

        // Reset, stream with k=1, then a 3-cycle stall as pc 8 returns
        lat = 1;
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        repeat (5) step(0, 1, 1, 0, 0);
        force_en = 1'b1; force_val = 32'h1234_5678;
        repeat (3) step(0, 0, 0, 0, 0);
        repeat (4) step(0, 1, 1, 0, 0);

        // Redirect in WAIT one cycle after the request for 4, k=3
        lat = 3;
        step(1, 1, 1, 0, 0);
        repeat (5) step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 32'h0000_0100);
        repeat (7) step(0, 1, 1, 0, 0);

        // Redirect to a misaligned target while stalled in HOLD
        lat = 1;
        step(1, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0000_0203);
        repeat (4) step(0, 1, 1, 0, 0);

        // Reset while the request for 32'h40 is outstanding
        lat = 3;
        step(1, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 1, 32'h0000_0040);
        repeat (3) step(0, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        repeat (6) step(0, 1, 1, 0, 0);

        // Randomised traffic: latency, stalls, redirects, occasional reset
        repeat (2000) begin
            lat = $urandom_range(4, 1);
            rst = ($urandom_range(199, 0) == 0);
            pw  = ($urandom_range(3, 0) != 0);
            iw  = ($urandom_range(5, 0) != 0) ? pw : ~pw;
            br  = ($urandom_range(11, 0) == 0);
            tgt = $urandom;
            if ($urandom_range(3, 0) == 0)
                tgt = 32'hFFFF_FFFC | 32'($urandom_range(3, 0));
            step(rst, pw, iw, br, tgt);
        end
        repeat (6) step(0, 1, 1, 0, 0);

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0, cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage pipeline: owns the PC register, issues one-at-a-time requests to instruction memory, and drives the IF/ID pipeline register consumed by decode and the hazard detection unit. It honours the load-use stall controls (`PCWrite`, `IF_ID_Write`) and the EX-stage branch redirect. On a redirect it flushes IF/ID and discards any in-flight fetch.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP`, default 32'h0000_0013: instruction word (`addi x0,x0,0`) placed in IF/ID on a bubble or flush.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `PCWrite` in 1: from hazard detection; 0 = hold PC.
- `IF_ID_Write` in 1: from hazard detection; 0 = hold IF/ID.
- `branch_taken` in 1: redirect request from EX.
- `branch_target` in 32: redirect address; bits [1:0] forced to 0 internally.
- `imem_req` out 1: one-cycle fetch request pulse.
- `imem_addr` out 32: fetch address, valid while `imem_req`=1.
- `imem_rvalid` in 1: response valid, exactly one per request, at least 1 cycle after it.
- `imem_rdata` in 32: instruction word, valid with `imem_rvalid`.
- `if_id_pc` out 32: IF/ID PC.
- `if_id_instr` out 32: IF/ID instruction.
- `if_id_valid` out 1: IF/ID holds a real instruction.

## Operation

- advance = `PCWrite` & `IF_ID_Write`. The hazard unit drives both together; either one low means stall.
- Registers:
  - `pc`
  - `state` ∈ {REQ, WAIT, HOLD}
  - `discard` flag
  - 32-bit `hold_buf`
  - IF/ID {pc, instr, valid}
- **REQ:** `imem_req`=1, `imem_addr`=`pc`; next state WAIT. `imem_rvalid` in REQ is a protocol error and is ignored.
- **WAIT:** `imem_req`=0. On `imem_rvalid`:
  - If `discard`=1: drop the data, clear `discard`, go to REQ.
  - Else if advance: IF/ID ← {`pc`, `imem_rdata`, 1}, `pc` ← `pc`+4, go to REQ.
  - Else: `hold_buf` ← `imem_rdata`, go to HOLD.
- **HOLD:** on advance, IF/ID ← {`pc`, `hold_buf`, 1}, `pc` ← `pc`+4, go to REQ. Otherwise remain in HOLD.
- **Bubble:** in any cycle where advance=1 and no instruction is loaded per the above, IF/ID ← {`pc`, `NOP`, 0}.
- **Stall without new data:** when advance=0, IF/ID holds its value.
- **Redirect** (`branch_taken`=1) has priority over stall and over any response:
  - `pc` ← `branch_target` & ~3.
  - IF/ID ← {0, `NOP`, 0}, regardless of `IF_ID_Write`.
  - In REQ: the request issued this cycle is stale; go to WAIT with `discard` ← 1.
  - In WAIT without `imem_rvalid`: `discard` ← 1 and stay in WAIT.
  - In WAIT with `imem_rvalid`: drop the data, go to REQ.
  - In HOLD: drop `hold_buf`, go to REQ.
- **Arithmetic:** `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.

## Timing

- Reset values:
  - `pc`=`RESET_PC`, `state`=REQ, `discard`=0.
  - `imem_req`=0 while `reset`=1; `imem_addr`=`RESET_PC`.
  - `if_id_pc`=0, `if_id_instr`=`NOP`, `if_id_valid`=0.
- The first request is issued in the first cycle after `reset` deasserts.
- `imem_req`/`imem_addr` are combinational from `state`/`pc` and are gated low by `reset`.
- Latency: request in cycle n, response in cycle n+k (k≥1), IF/ID updated at the end of cycle n+k.
- Throughput: with k=1 and no stalls, one instruction every 2 cycles.
- Reset mid-operation: the instruction memory shares `reset`, so no response for a pre-reset request ever arrives. The block returns to the reset state with no dependence on prior state.
- At most one request is outstanding at any time. `imem_req` never asserts in WAIT or HOLD.

## Test plan

- **Reset and stream:** `RESET_PC`=0, k=1 memory returning addr^32'hA5A5_0000, no stalls.
  - Required: `imem_addr` sequence 0, 4, 8.
  - Required: IF/ID gets (0, 32'hA5A5_0000, 1) and then (4, 32'hA5A5_0004, 1), 2 cycles apart.
  - Required: `if_id_valid` is 0 in the intervening bubble cycles.
- **Stall on response:** advance=0 in the cycle `imem_rvalid` returns 32'h1234_5678 for pc 8, held for 3 cycles.
  - Required: IF/ID is unchanged while stalled and no `imem_req` is issued.
  - Required: on release, IF/ID becomes (8, 32'h1234_5678, 1) and the next request is to 12.
- **Redirect in WAIT:** k=3; `branch_taken`=1 with target 32'h100 one cycle after the request for 4.
  - Required: the response for 4 is dropped and IF/ID is flushed to valid=0/`NOP`.
  - Required: the next `imem_addr` is 32'h100.
- **Redirect plus stall:** `branch_taken`=1 with target 32'h203, with advance=0, while in HOLD.
  - Required: the flush still occurs, `hold_buf` is dropped, and the next `imem_addr` is 32'h200.
- **Wrap:** `RESET_PC`=32'hFFFF_FFFC.
  - Required: the second `imem_addr` is 32'h0000_0000.
- **Reset mid-WAIT:** assert `reset` for 1 cycle while a request for 32'h40 is outstanding.
  - Required: all outputs return to reset values.
  - Required: the next request is to `RESET_PC`, and `if_id_valid` stays 0 until that response arrives.
